// File: rtl/multicycle_control.sv
// Main control FSM for the shared multicycle datapath. It decodes the
// instruction-register opcode and drives the datapath enables, mux selects and
// extender mode for each cycle. Memory accesses stall on mem_ready_i, and
// retire_o pulses once for every instruction that completes.
module multicycle_control (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       run_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_beq_o,
    output logic       pc_write_bne_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       ext_sel_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    // Supported opcodes (instr[31:26])
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // ALU operation selects
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_LOGIC = 2'd3;

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMM4 = 2'd3;

    // PC source selects
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEXE = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    // One control word per cycle. Each state starts from all-zero and sets only
    // the fields it needs, so an unlisted output is always 0.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_sel;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctl;

    // andi/ori use the logical ALU op and zero-extend their immediate. addi
    // keeps sign extension.
    logic op_logical;
    assign op_logical = (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);

    // Where to go after an instruction finishes: keep fetching while run is high.
    state_e after_retire;
    assign after_retire = run_i ? S_FETCH : S_IDLE;

    // State register. Reset forces IDLE at once, which also drops any memory
    // request that is in progress.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and Moore outputs. Only the mem_ready qualified strobes
    // depend on an input.
    always_comb begin
        state_d = state_q;
        ctl     = '0;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.iord      = 1'b0;
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALU_ADD;
                ctl.pc_source = PCS_ALU;
                if (mem_ready_i) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Compute the branch target speculatively: PC + (sext(imm) << 2).
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_IMM4;
                ctl.alu_op    = ALU_ADD;
                ctl.ext_sel   = 1'b0;
                case (opcode_i)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_R:                    state_d = S_EXEC;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEXE;
                    OP_J:                    state_d = S_JUMP;
                    default: begin
                        ctl.illegal = 1'b1;
                        state_d     = after_retire;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALU_ADD;
                ctl.ext_sel   = 1'b0;
                state_d       = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b0;
                ctl.mem_to_reg = 1'b1;
                ctl.retire     = 1'b1;
                state_d        = after_retire;
            end
            S_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (mem_ready_i) begin
                    ctl.retire = 1'b1;
                    state_d    = after_retire;
                end
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
                ctl.alu_op    = ALU_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.mem_to_reg = 1'b0;
                ctl.retire     = 1'b1;
                state_d        = after_retire;
            end
            S_BRANCH: begin
                // Compare A and B with a subtract. The PC is loaded from ALUOut,
                // which holds the target computed in DECODE.
                ctl.alu_src_a    = 1'b1;
                ctl.alu_src_b    = SRCB_REG;
                ctl.alu_op       = ALU_SUB;
                ctl.pc_source    = PCS_ALUOUT;
                ctl.pc_write_beq = (opcode_i == OP_BEQ);
                ctl.pc_write_bne = (opcode_i == OP_BNE);
                ctl.retire       = 1'b1;
                state_d          = after_retire;
            end
            S_IMMEXE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = op_logical ? ALU_LOGIC : ALU_ADD;
                ctl.ext_sel   = op_logical;
                state_d       = S_IMMWB;
            end
            S_IMMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b0;
                ctl.mem_to_reg = 1'b0;
                ctl.ext_sel    = op_logical;
                ctl.retire     = 1'b1;
                state_d        = after_retire;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCS_JUMP;
                ctl.retire    = 1'b1;
                state_d       = after_retire;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc_write_o     = ctl.pc_write;
    assign pc_write_beq_o = ctl.pc_write_beq;
    assign pc_write_bne_o = ctl.pc_write_bne;
    assign iord_o         = ctl.iord;
    assign mem_read_o     = ctl.mem_read;
    assign mem_write_o    = ctl.mem_write;
    assign ir_write_o     = ctl.ir_write;
    assign reg_dst_o      = ctl.reg_dst;
    assign mem_to_reg_o   = ctl.mem_to_reg;
    assign reg_write_o    = ctl.reg_write;
    assign alu_src_a_o    = ctl.alu_src_a;
    assign alu_src_b_o    = ctl.alu_src_b;
    assign alu_op_o       = ctl.alu_op;
    assign pc_source_o    = ctl.pc_source;
    assign ext_sel_o      = ctl.ext_sel;
    assign retire_o       = ctl.retire;
    assign illegal_o      = ctl.illegal;
    assign state_o        = state_q;

endmodule
